// File: rtl/display_bus_arbiter.sv
// Two-plane display read arbiter: grants one decoder per memory burst, routes the burst
// beats back to it, and discards the beats of a burst whose owner reloaded mid-flight.
module display_bus_arbiter #(
   parameter int unsigned BURST_WORDS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [21:0] req0_address,
   input  logic        req0_as,
   input  logic        req0_cancel,
   output logic        req0_bus_ack,
   output logic        req0_burstdata_valid,
   input  logic [21:0] req1_address,
   input  logic        req1_as,
   input  logic        req1_cancel,
   output logic        req1_bus_ack,
   output logic        req1_burstdata_valid,
   output logic [15:0] dout,
   output logic [21:0] mem_address,
   output logic        mem_as,
   input  logic        mem_bus_ack,
   input  logic [15:0] mem_din,
   input  logic        mem_burstdata_valid
);

   typedef enum logic [1:0] {StIdle, StAddr, StBurst} state_e;

   localparam logic [2:0] LastCnt = 3'(BURST_WORDS);

   state_e      state_q, state_d;
   logic        grant_q, grant_d;
   logic        prio_q, prio_d;
   logic        drop_q, drop_d;
   logic        mem_as_q, mem_as_d;
   logic [2:0]  beat_cnt_q, beat_cnt_d;
   logic [21:0] mem_address_q, mem_address_d;

   logic elig0, elig1, active, cancel_g, beat, last_beat, route, ack_g;

   assign elig0     = req0_as & ~req0_cancel;
   assign elig1     = req1_as & ~req1_cancel;
   assign active    = (state_q != StIdle);
   assign cancel_g  = grant_q ? req1_cancel : req0_cancel;
   assign beat      = active & mem_burstdata_valid;
   assign last_beat = beat & ((beat_cnt_q + 3'd1) == LastCnt);

   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      prio_d        = prio_q;
      drop_d        = drop_q;
      mem_as_d      = mem_as_q;
      beat_cnt_d    = beat_cnt_q;
      mem_address_d = mem_address_q;

      if (beat) beat_cnt_d = beat_cnt_q + 3'd1;
      if (active && cancel_g) drop_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (elig0 | elig1) begin
               grant_d       = (elig0 & elig1) ? prio_q : elig1;
               mem_address_d = grant_d ? req1_address : req0_address;
               mem_as_d      = 1'b1;
               beat_cnt_d    = 3'd0;
               drop_d        = 1'b0;
               state_d       = StAddr;
            end
         end
         StAddr: begin
            if (mem_bus_ack) begin
               mem_as_d = 1'b0;
               // A one-beat burst can complete on the address-accept cycle.
               if (last_beat) begin
                  state_d = StIdle;
                  prio_d  = ~grant_q;
               end else begin
                  state_d = StBurst;
               end
            end
         end
         StBurst: begin
            if (last_beat) begin
               state_d = StIdle;
               prio_d  = ~grant_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         grant_q       <= 1'b0;
         prio_q        <= 1'b0;
         drop_q        <= 1'b0;
         mem_as_q      <= 1'b0;
         beat_cnt_q    <= 3'd0;
         mem_address_q <= 22'd0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         prio_q        <= prio_d;
         drop_q        <= drop_d;
         mem_as_q      <= mem_as_d;
         beat_cnt_q    <= beat_cnt_d;
         mem_address_q <= mem_address_d;
      end
   end

   // Same-cycle cancel suppresses the beat before drop_q takes effect.
   assign route = beat & ~drop_q & ~cancel_g;
   assign ack_g = mem_bus_ack & (state_q == StAddr) & ~drop_q;

   assign req0_bus_ack         = ack_g & ~grant_q;
   assign req1_bus_ack         = ack_g & grant_q;
   assign req0_burstdata_valid = route & ~grant_q;
   assign req1_burstdata_valid = route & grant_q;
   assign dout                 = mem_din;
   assign mem_address          = mem_address_q;
   assign mem_as               = mem_as_q;

endmodule

// File: tb/tb_display_bus_arbiter.sv
// Scoreboarded bench for display_bus_arbiter: requesters push expected beats on issue,
// a negedge monitor pops and compares every routed beat and address acknowledge.
module tb_display_bus_arbiter;

   localparam int BW = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [21:0] req_addr [2];
   logic        req_as [2];
   logic        req_cancel [2];
   logic        req0_bus_ack, req1_bus_ack, req0_burstdata_valid, req1_burstdata_valid;
   logic [15:0] dout;
   logic [21:0] mem_address;
   logic        mem_as;
   logic        mem_bus_ack = 1'b0;
   logic [15:0] mem_din = 16'h0;
   logic        mem_burstdata_valid = 1'b0;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp0 [$];
   logic [15:0] exp1 [$];
   int          ack_cnt [2];
   int          val_cnt [2];
   int          ack_log [$];
   int          mon_n;
   logic        rnd_en = 1'b0, req_auto = 1'b0, mem_auto = 1'b0, mem_busy = 1'b0;

   display_bus_arbiter #(.BURST_WORDS(BW)) dut (
      .clk                  (clk),
      .reset                (reset),
      .req0_address         (req_addr[0]),
      .req0_as              (req_as[0]),
      .req0_cancel          (req_cancel[0]),
      .req0_bus_ack         (req0_bus_ack),
      .req0_burstdata_valid (req0_burstdata_valid),
      .req1_address         (req_addr[1]),
      .req1_as              (req_as[1]),
      .req1_cancel          (req_cancel[1]),
      .req1_bus_ack         (req1_bus_ack),
      .req1_burstdata_valid (req1_burstdata_valid),
      .dout                 (dout),
      .mem_address          (mem_address),
      .mem_as               (mem_as),
      .mem_bus_ack          (mem_bus_ack),
      .mem_din              (mem_din),
      .mem_burstdata_valid  (mem_burstdata_valid)
   );

   always #5 clk = ~clk;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Memory content is a fixed function of the burst address and beat index.
   function automatic logic [15:0] data_of(input logic [21:0] a, input int k);
      return a[15:0] + 16'h00A0 + 16'(k);
   endfunction

   function automatic void push_burst(input int n, input logic [21:0] a, input int beats);
      for (int k = 0; k < beats; k++) begin
         if (n == 0) exp0.push_back(data_of(a, k));
         else exp1.push_back(data_of(a, k));
      end
   endfunction

   function automatic void clear_exp(input int n);
      if (n == 0) exp0.delete();
      else exp1.delete();
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (req0_bus_ack | req1_bus_ack) begin
            check("ack_onehot", 32'(req0_bus_ack & req1_bus_ack), 32'd0);
            mon_n = req1_bus_ack ? 1 : 0;
            check("ack_mem_address", 32'(mem_address), 32'(req_addr[mon_n]));
            ack_cnt[mon_n]++;
            ack_log.push_back(mon_n);
         end
         if (req0_burstdata_valid | req1_burstdata_valid) begin
            check("valid_onehot", 32'(req0_burstdata_valid & req1_burstdata_valid), 32'd0);
            mon_n = req1_burstdata_valid ? 1 : 0;
            val_cnt[mon_n]++;
            checks++;
            if ((mon_n == 0 && exp0.size() == 0) || (mon_n == 1 && exp1.size() == 0)) begin
               errors++;
               $display("FAIL beat_unexpected: req%0d got beat %0h, expected none", mon_n, dout);
            end else begin
               checks--;
               if (mon_n == 0) check("beat_data_req0", 32'(dout), 32'(exp0.pop_front()));
               else check("beat_data_req1", 32'(dout), 32'(exp1.pop_front()));
            end
         end
      end
   end

   task automatic requester(input int n);
      logic acked;
      int   r;
      forever begin
         @(negedge clk);
         acked = (n == 0) ? req0_bus_ack : req1_bus_ack;
         tick();
         if (req_auto) begin
            if (rnd_en) req_cancel[n] = 1'b0;
            if (acked) begin
               req_as[n] = 1'b0;
            end else if (rnd_en) begin
               r = int'($urandom_range(0, 99));
               if (r < 3) begin
                  req_cancel[n] = 1'b1;
                  req_as[n]     = 1'b0;
                  clear_exp(n);
               end else if (!req_as[n] && r < 25) begin
                  req_addr[n] = 22'($urandom);
                  req_as[n]   = 1'b1;
                  push_burst(n, req_addr[n], BW);
               end
            end
         end
      end
   endtask

   initial requester(0);
   initial requester(1);

   // Serves one burst: waits for mem_as, acks after ack_dly cycles, streams BW beats.
   task automatic mem_serve(input int ack_dly, input bit beat_on_ack, input bit gaps,
                            input bit stray);
      logic [21:0] a;
      int          k;
      int          guard;
      mem_busy = 1'b1;
      guard = 0;
      while (!mem_as && guard < 50) begin
         tick();
         guard++;
      end
      if (!mem_as) begin
         checks++;
         errors++;
         $display("FAIL mem_as_timeout: got mem_as 0 after 50 cycles, expected 1");
         mem_busy = 1'b0;
         return;
      end
      repeat (ack_dly) tick();
      a = mem_address;
      mem_bus_ack = 1'b1;
      k = 0;
      if (beat_on_ack) begin
         mem_burstdata_valid = 1'b1;
         mem_din = data_of(a, 0);
         k = 1;
      end
      tick();
      mem_bus_ack = 1'b0;
      mem_burstdata_valid = 1'b0;
      while (k < BW) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            mem_burstdata_valid = 1'b0;
         end else begin
            mem_burstdata_valid = 1'b1;
            mem_din = data_of(a, k);
            k++;
         end
         tick();
      end
      mem_burstdata_valid = stray;
      mem_din = 16'hDEAD;
      check("idle_gap_mem_as", 32'(mem_as), 32'd0);
      tick();
      mem_burstdata_valid = 1'b0;
      mem_busy = 1'b0;
   endtask

   initial begin
      forever begin
         if (mem_auto && mem_as && !reset)
            mem_serve(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1,
                      1'($urandom_range(0, 1)));
         else tick();
      end
   end

   task automatic reset_dut();
      reset = 1'b1;
      req_as[0] = 1'b0;
      req_as[1] = 1'b0;
      req_cancel[0] = 1'b0;
      req_cancel[1] = 1'b0;
      mem_bus_ack = 1'b0;
      mem_burstdata_valid = 1'b0;
      tick();
      tick();
      check("rst_mem_as", 32'(mem_as), 32'd0);
      check("rst_mem_address", 32'(mem_address), 32'd0);
      check("rst_acks", 32'({req0_bus_ack, req1_bus_ack}), 32'd0);
      check("rst_valids", 32'({req0_burstdata_valid, req1_burstdata_valid}), 32'd0);
      reset = 1'b0;
      exp0.delete();
      exp1.delete();
      ack_log.delete();
      ack_cnt = '{0, 0};
      val_cnt = '{0, 0};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      req_addr[0] = '0;
      req_addr[1] = '0;

      // Single requester, ack two cycles after mem_as.
      reset_dut();
      req_auto = 1'b1;
      req_addr[0] = 22'h001000;
      req_as[0] = 1'b1;
      push_burst(0, req_addr[0], BW);
      tick();
      check("t1_mem_as", 32'(mem_as), 32'd1);
      check("t1_mem_address", 32'(mem_address), 32'h001000);
      mem_serve(2, 1'b0, 1'b0, 1'b0);
      check("t1_ack0", ack_cnt[0], 1);
      check("t1_val0", val_cnt[0], BW);
      check("t1_other", ack_cnt[1] + val_cnt[1], 0);

      // Both held continuously: grants alternate from reset priority.
      reset_dut();
      req_auto = 1'b0;
      req_addr[0] = 22'h011111;
      req_addr[1] = 22'h022222;
      push_burst(0, req_addr[0], BW);
      push_burst(0, req_addr[0], BW);
      push_burst(1, req_addr[1], BW);
      push_burst(1, req_addr[1], BW);
      req_as[0] = 1'b1;
      req_as[1] = 1'b1;
      mem_serve(1, 1'b0, 1'b1, 1'b0);
      mem_serve(2, 1'b1, 1'b1, 1'b0);
      mem_serve(0, 1'b0, 1'b1, 1'b0);
      req_as[0] = 1'b0;
      req_as[1] = 1'b0;
      mem_serve(3, 1'b0, 1'b1, 1'b0);
      check("t2_grant_count", ack_log.size(), 4);
      for (int i = 0; i < ack_log.size() && i < 4; i++) check("t2_grant_order", ack_log[i], i % 2);
      check("t2_val", val_cnt[0] + val_cnt[1], 4 * BW);

      // req1 cancels after its first beat.
      reset_dut();
      req_auto = 1'b1;
      req_addr[1] = 22'h2A0040;
      req_as[1] = 1'b1;
      push_burst(1, req_addr[1], 1);
      tick();
      check("t3_mem_as", 32'(mem_as), 32'd1);
      mem_bus_ack = 1'b1;
      tick();
      mem_bus_ack = 1'b0;
      for (int k = 0; k < BW; k++) begin
         mem_burstdata_valid = 1'b1;
         mem_din = data_of(22'h2A0040, k);
         req_cancel[1] = (k == 1);
         if (k == 1) exp1.delete();
         tick();
      end
      mem_burstdata_valid = 1'b0;
      req_cancel[1] = 1'b0;
      check("t3_val1", val_cnt[1], 1);
      req_addr[0] = 22'h000777;
      req_addr[1] = 22'h300000;
      push_burst(0, req_addr[0], BW);
      req_as[0] = 1'b1;
      req_as[1] = 1'b1;
      tick();
      check("t3_regrant_as", 32'(mem_as), 32'd1);
      check("t3_prio0", 32'(mem_address), 32'h000777);
      req_as[1] = 1'b0;
      mem_serve(0, 1'b0, 1'b0, 1'b0);
      check("t3_val0", val_cnt[0], BW);

      // mem_bus_ack together with the first beat.
      reset_dut();
      req_addr[1] = 22'h0C0DE0;
      req_as[1] = 1'b1;
      push_burst(1, req_addr[1], BW);
      mem_serve(1, 1'b1, 1'b0, 1'b0);
      check("t4_val1", val_cnt[1], BW);
      check("t4_ack1", ack_cnt[1], 1);

      // Reset in the middle of a burst.
      reset_dut();
      req_addr[0] = 22'h0ABCDE;
      req_as[0] = 1'b1;
      push_burst(0, req_addr[0], 2);
      tick();
      mem_bus_ack = 1'b1;
      tick();
      mem_bus_ack = 1'b0;
      for (int k = 0; k < 2; k++) begin
         mem_burstdata_valid = 1'b1;
         mem_din = data_of(22'h0ABCDE, k);
         tick();
      end
      check("t5_val_before_reset", val_cnt[0], 2);
      reset_dut();
      req_addr[0] = 22'h055AA0;
      req_as[0] = 1'b1;
      push_burst(0, req_addr[0], BW);
      mem_serve(1, 1'b0, 1'b1, 1'b0);
      check("t5_fresh_val0", val_cnt[0], BW);

      // Stray beats while idle.
      reset_dut();
      mem_burstdata_valid = 1'b1;
      mem_din = 16'hBEEF;
      tick();
      tick();
      mem_burstdata_valid = 1'b0;
      check("t6_no_route", val_cnt[0] + val_cnt[1], 0);
      req_addr[1] = 22'h123456;
      req_as[1] = 1'b1;
      push_burst(1, req_addr[1], BW);
      mem_serve(1, 1'b1, 1'b0, 1'b0);
      check("t6_full_burst", val_cnt[1], BW);

      // Randomized traffic with cancels and stray beats.
      reset_dut();
      req_auto = 1'b1;
      rnd_en = 1'b1;
      mem_auto = 1'b1;
      repeat (3000) tick();
      rnd_en = 1'b0;
      req_cancel[0] = 1'b0;
      req_cancel[1] = 1'b0;
      guard = 0;
      while ((req_as[0] || req_as[1] || mem_busy || mem_as || exp0.size() != 0 ||
              exp1.size() != 0) && guard < 1000) begin
         tick();
         guard++;
      end
      check("rnd_drain_exp0", exp0.size(), 0);
      check("rnd_drain_exp1", exp1.size(), 0);
      check("rnd_drain_as", 32'({req_as[0], req_as[1]}), 32'd0);
      check("rnd_activity", 32'(ack_cnt[0] > 0 && ack_cnt[1] > 0), 32'd1);
      mem_auto = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
